// File: rtl/icache_pkg.sv
// Shared widths/constants plus the icache state encoding and default geometry.
package icache_pkg;
    localparam int   PcLength      = 32;
    localparam int   InstrLength   = 32;
    localparam logic True          = 1'b1;
    localparam logic False         = 1'b0;
    localparam int   DefIndexWidth = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        MISS       = 2'd1,
        FLUSH_WAIT = 2'd2,
        COOLDOWN   = 2'd3
    } icache_state_e;
endpackage

// File: rtl/icache_if.sv
// Fetch-side (iq/rob) and memory-side (mc) signals of the instruction cache.
interface icache_if;
    import icache_pkg::*;

    logic                   is_exception_from_rob;
    logic                   is_empty_from_iq;
    logic [PcLength-1:0]    pc_from_iq;
    logic                   is_hit_to_iq;
    logic [InstrLength-1:0] instr_to_iq;
    logic                   is_request_to_mc;
    logic [PcLength-1:0]    addr_to_mc;
    logic                   is_finish_from_mc;
    logic [InstrLength-1:0] data_from_mc;

    modport master (
        output is_exception_from_rob, is_empty_from_iq, pc_from_iq,
        output is_finish_from_mc, data_from_mc,
        input  is_hit_to_iq, instr_to_iq, is_request_to_mc, addr_to_mc
    );

    modport slave (
        input  is_exception_from_rob, is_empty_from_iq, pc_from_iq,
        input  is_finish_from_mc, data_from_mc,
        output is_hit_to_iq, instr_to_iq, is_request_to_mc, addr_to_mc
    );
endinterface

// File: rtl/icache_array.sv
// Direct-mapped line storage: combinational lookup, synchronous fill.
module icache_array
    import icache_pkg::*;
#(
    parameter int IndexWidth = DefIndexWidth,
    parameter int TagWidth   = PcLength - IndexWidth - 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IndexWidth-1:0]  i_rd_idx,
    input  logic [TagWidth-1:0]    i_rd_tag,
    output logic                   o_rd_hit,
    output logic [InstrLength-1:0] o_rd_data,
    input  logic                   i_wr_en,
    input  logic [IndexWidth-1:0]  i_wr_idx,
    input  logic [TagWidth-1:0]    i_wr_tag,
    input  logic [InstrLength-1:0] i_wr_data
);
    localparam int Lines = 1 << IndexWidth;

    logic [Lines-1:0]       r_valid;
    logic [TagWidth-1:0]    r_tag  [Lines];
    logic [InstrLength-1:0] r_data [Lines];

    // Only valid bits need clearing; tag/data are qualified by them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= True;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_hit  = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
    assign o_rd_data = r_data[i_rd_idx];
endmodule

// File: rtl/icache.sv
// Instruction cache controller: lookup, miss handling toward mc, flush recovery.
module icache
    import icache_pkg::*;
#(
    parameter int IndexWidth = DefIndexWidth,
    parameter int TagWidth   = PcLength - IndexWidth - 2
) (
    input  logic   clk,
    input  logic   rst,
    icache_if.slave bus
);
    icache_state_e          r_state, w_state;
    logic                   r_hit, w_hit;
    logic [InstrLength-1:0] r_instr, w_instr;
    logic                   r_req, w_req;
    logic [PcLength-1:0]    r_addr, w_addr;
    logic                   w_we;
    logic                   w_lookup_hit;
    logic [InstrLength-1:0] w_lookup_data;
    logic                   w_unused_ok;

    icache_array #(.IndexWidth(IndexWidth), .TagWidth(TagWidth)) u_array (
        .clk       (clk),
        .rst       (rst),
        .i_rd_idx  (bus.pc_from_iq[IndexWidth+1:2]),
        .i_rd_tag  (bus.pc_from_iq[PcLength-1:IndexWidth+2]),
        .o_rd_hit  (w_lookup_hit),
        .o_rd_data (w_lookup_data),
        .i_wr_en   (w_we),
        .i_wr_idx  (r_addr[IndexWidth+1:2]),
        .i_wr_tag  (r_addr[PcLength-1:IndexWidth+2]),
        .i_wr_data (bus.data_from_mc)
    );

    assign w_unused_ok = ^{bus.pc_from_iq[1:0], r_addr[1:0]};

    always_comb begin
        w_state = r_state;
        w_hit   = False;
        w_instr = r_instr;
        w_req   = r_req;
        w_addr  = r_addr;
        w_we    = False;
        unique case (r_state)
            IDLE: begin
                if (!bus.is_exception_from_rob && !bus.is_empty_from_iq) begin
                    if (w_lookup_hit) begin
                        w_hit   = True;
                        w_instr = w_lookup_data;
                        w_state = COOLDOWN;
                    end else begin
                        w_req   = True;
                        w_addr  = {bus.pc_from_iq[PcLength-1:2], 2'b00};
                        w_state = MISS;
                    end
                end
            end
            MISS: begin
                if (bus.is_finish_from_mc) begin
                    w_we  = True;
                    w_req = False;
                    if (bus.is_exception_from_rob) begin
                        w_state = IDLE;
                    end else begin
                        w_hit   = True;
                        w_instr = bus.data_from_mc;
                        w_state = COOLDOWN;
                    end
                end else if (bus.is_exception_from_rob) begin
                    // mc cannot abort, so keep requesting and drain the reply.
                    w_state = FLUSH_WAIT;
                end
            end
            FLUSH_WAIT: begin
                if (bus.is_finish_from_mc) begin
                    w_we    = True;
                    w_req   = False;
                    w_state = IDLE;
                end
            end
            COOLDOWN: w_state = IDLE;
            default:  w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_hit   <= False;
            r_instr <= '0;
            r_req   <= False;
            r_addr  <= '0;
        end else begin
            r_state <= w_state;
            r_hit   <= w_hit;
            r_instr <= w_instr;
            r_req   <= w_req;
            r_addr  <= w_addr;
        end
    end

    assign bus.is_hit_to_iq     = r_hit;
    assign bus.instr_to_iq      = r_instr;
    assign bus.is_request_to_mc = r_req;
    assign bus.addr_to_mc       = r_addr;
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: miss/hit/conflict/flush/reset sequences.
module tb_icache;
    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    icache_if bus_if();

    icache dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic hit, input logic req);
        chk({tag, ".hit"}, {31'd0, bus_if.is_hit_to_iq}, {31'd0, hit});
        chk({tag, ".req"}, {31'd0, bus_if.is_request_to_mc}, {31'd0, req});
    endtask

    initial begin
        rst = 1'b1;
        bus_if.is_exception_from_rob = 1'b0;
        bus_if.is_empty_from_iq      = 1'b1;
        bus_if.pc_from_iq            = 32'h0;
        bus_if.is_finish_from_mc     = 1'b0;
        bus_if.data_from_mc          = 32'h0;
        tick();
        tick();
        chk_out("reset", 1'b0, 1'b0);
        chk("reset.instr", bus_if.instr_to_iq, 32'h0);
        chk("reset.addr", bus_if.addr_to_mc, 32'h0);
        rst = 1'b0;
        tick();

        // Cold miss on 0x1000; iq keeps presenting the PC throughout.
        bus_if.pc_from_iq = 32'h0000_1000;
        bus_if.is_empty_from_iq = 1'b0;
        tick();
        chk_out("cold.req", 1'b0, 1'b1);
        chk("cold.addr", bus_if.addr_to_mc, 32'h0000_1000);
        tick();
        chk_out("cold.wait1", 1'b0, 1'b1);
        tick();
        chk_out("cold.wait2", 1'b0, 1'b1);
        bus_if.is_finish_from_mc = 1'b1;
        bus_if.data_from_mc = 32'h0000_0513;
        tick();
        bus_if.is_finish_from_mc = 1'b0;
        chk_out("cold.fill", 1'b1, 1'b0);
        chk("cold.instr", bus_if.instr_to_iq, 32'h0000_0513);
        tick();
        chk_out("cooldown.ignore", 1'b0, 1'b0);
        tick();
        chk_out("warm.hit", 1'b1, 1'b0);
        chk("warm.instr", bus_if.instr_to_iq, 32'h0000_0513);
        bus_if.is_empty_from_iq = 1'b1;
        tick();
        chk_out("warm.cooldown", 1'b0, 1'b0);
        tick();

        // Conflict: 0x0 and 0x400 share index 0.
        bus_if.pc_from_iq = 32'h0000_0000;
        bus_if.is_empty_from_iq = 1'b0;
        tick();
        chk_out("conf0.req", 1'b0, 1'b1);
        chk("conf0.addr", bus_if.addr_to_mc, 32'h0000_0000);
        bus_if.is_empty_from_iq = 1'b0;
        bus_if.is_finish_from_mc = 1'b1;
        bus_if.data_from_mc = 32'hAAAA_0000;
        tick();
        bus_if.is_finish_from_mc = 1'b0;
        bus_if.is_empty_from_iq = 1'b1;
        chk("conf0.instr", bus_if.instr_to_iq, 32'hAAAA_0000);
        tick();
        bus_if.pc_from_iq = 32'h0000_0400;
        bus_if.is_empty_from_iq = 1'b0;
        tick();
        chk_out("conf400.miss", 1'b0, 1'b1);
        chk("conf400.addr", bus_if.addr_to_mc, 32'h0000_0400);
        bus_if.is_empty_from_iq = 1'b1;
        bus_if.is_finish_from_mc = 1'b1;
        bus_if.data_from_mc = 32'hBBBB_0400;
        tick();
        bus_if.is_finish_from_mc = 1'b0;
        chk_out("conf400.fill", 1'b1, 1'b0);
        chk("conf400.instr", bus_if.instr_to_iq, 32'hBBBB_0400);
        tick();
        bus_if.pc_from_iq = 32'h0000_0000;
        bus_if.is_empty_from_iq = 1'b0;
        tick();
        chk_out("conf0.remiss", 1'b0, 1'b1);
        chk("conf0.readdr", bus_if.addr_to_mc, 32'h0000_0000);
        bus_if.is_empty_from_iq = 1'b1;
        bus_if.is_finish_from_mc = 1'b1;
        bus_if.data_from_mc = 32'hAAAA_0000;
        tick();
        bus_if.is_finish_from_mc = 1'b0;
        chk_out("conf0.refill", 1'b1, 1'b0);
        tick();

        // Exception one cycle into a miss: request persists, no hit.
        bus_if.pc_from_iq = 32'h0000_2000;
        bus_if.is_empty_from_iq = 1'b0;
        tick();
        chk_out("exc.req", 1'b0, 1'b1);
        bus_if.is_empty_from_iq = 1'b1;
        bus_if.is_exception_from_rob = 1'b1;
        tick();
        bus_if.is_exception_from_rob = 1'b0;
        chk_out("exc.held", 1'b0, 1'b1);
        chk("exc.addr", bus_if.addr_to_mc, 32'h0000_2000);
        tick();
        chk_out("exc.held2", 1'b0, 1'b1);
        bus_if.is_finish_from_mc = 1'b1;
        bus_if.data_from_mc = 32'h1234_5678;
        tick();
        bus_if.is_finish_from_mc = 1'b0;
        chk_out("exc.drain", 1'b0, 1'b0);
        bus_if.is_empty_from_iq = 1'b0;
        tick();
        chk_out("exc.rehit", 1'b1, 1'b0);
        chk("exc.reinstr", bus_if.instr_to_iq, 32'h1234_5678);
        bus_if.is_empty_from_iq = 1'b1;
        tick();

        // Exception coincident with finish: fill, no hit, back to IDLE.
        bus_if.pc_from_iq = 32'h0000_3000;
        bus_if.is_empty_from_iq = 1'b0;
        tick();
        chk_out("excfin.req", 1'b0, 1'b1);
        bus_if.is_empty_from_iq = 1'b1;
        bus_if.is_finish_from_mc = 1'b1;
        bus_if.is_exception_from_rob = 1'b1;
        bus_if.data_from_mc = 32'hCAFE_0001;
        tick();
        bus_if.is_finish_from_mc = 1'b0;
        bus_if.is_exception_from_rob = 1'b0;
        chk_out("excfin.nohit", 1'b0, 1'b0);
        bus_if.is_empty_from_iq = 1'b0;
        tick();
        chk_out("excfin.rehit", 1'b1, 1'b0);
        chk("excfin.instr", bus_if.instr_to_iq, 32'hCAFE_0001);
        bus_if.is_empty_from_iq = 1'b1;
        tick();

        // Exception while IDLE suppresses a would-be hit.
        bus_if.pc_from_iq = 32'h0000_1000;
        bus_if.is_empty_from_iq = 1'b0;
        bus_if.is_exception_from_rob = 1'b1;
        tick();
        chk_out("excidle", 1'b0, 1'b0);
        bus_if.is_exception_from_rob = 1'b0;
        bus_if.is_empty_from_iq = 1'b1;
        tick();

        // Reset mid-miss clears outputs and invalidates all lines.
        bus_if.pc_from_iq = 32'h0000_4000;
        bus_if.is_empty_from_iq = 1'b0;
        tick();
        chk_out("rstmiss.req", 1'b0, 1'b1);
        rst = 1'b1;
        bus_if.is_empty_from_iq = 1'b1;
        tick();
        chk_out("rstmiss.clr", 1'b0, 1'b0);
        chk("rstmiss.addr", bus_if.addr_to_mc, 32'h0);
        rst = 1'b0;
        tick();
        bus_if.pc_from_iq = 32'h0000_1000;
        bus_if.is_empty_from_iq = 1'b0;
        tick();
        chk_out("rstmiss.cold", 1'b0, 1'b1);
        chk("rstmiss.coldaddr", bus_if.addr_to_mc, 32'h0000_1000);
        bus_if.is_empty_from_iq = 1'b1;
        bus_if.is_finish_from_mc = 1'b1;
        bus_if.data_from_mc = 32'h0000_0005;
        tick();
        bus_if.is_finish_from_mc = 1'b0;
        chk_out("rstmiss.fill", 1'b1, 1'b0);
        chk("rstmiss.instr", bus_if.instr_to_iq, 32'h0000_0005);
        tick();
        chk_out("final.quiet", 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
